// File: rtl/lsu_pkg.sv
// Shared types and RISC-V funct3 encodings for the load/store unit.
package lsu_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, RMW_WRITE, RESP} lsu_state_t;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LD  = 3'd3;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_LWU = 3'd6;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;
    localparam logic [2:0] F3_SD  = 3'd3;

    typedef struct packed {
        logic        is_load;
        logic [2:0]  funct3;
        logic [2:0]  offset;
        logic [63:0] store_data;
    } lsu_req_t;

    // Byte-lane mask for an access of 1/2/4/8 bytes, LSB-aligned.
    function automatic logic [63:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'd0:    return 64'h0000_0000_0000_00FF;
            2'd1:    return 64'h0000_0000_0000_FFFF;
            2'd2:    return 64'h0000_0000_FFFF_FFFF;
            default: return '1;
        endcase
    endfunction
endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed lane out of a memory word and sign/zero-extends it.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [63:0] word,
    input  logic [2:0]  offset,
    input  logic [2:0]  funct3,
    output logic [63:0] data
);
    logic [63:0] sh;
    assign sh = word >> {offset, 3'b000};

    always_comb begin
        data = sh;
        case (funct3)
            F3_LB:   data = {{56{sh[7]}},  sh[7:0]};
            F3_LH:   data = {{48{sh[15]}}, sh[15:0]};
            F3_LW:   data = {{32{sh[31]}}, sh[31:0]};
            F3_LBU:  data = {56'd0, sh[7:0]};
            F3_LHU:  data = {48'd0, sh[15:0]};
            F3_LWU:  data = {32'd0, sh[31:0]};
            default: data = sh;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit over a word-indexed 64-bit data memory;
// sub-word stores are done as read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [63:0] addr,
    input  logic [63:0] store_data,
    output logic        resp_valid,
    output logic [63:0] load_data,
    output logic        fault,
    output logic        mem_read,
    output logic        mem_write,
    output logic [63:0] mem_address,
    output logic [63:0] mem_write_data,
    input  logic [63:0] mem_read_data
);
    lsu_state_t  state;
    lsu_req_t    req;
    logic        mem_write_r;
    logic        req_bad;
    logic [63:0] load_word, lane_mask, merged;

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    // Reset wins over a pending write in the same cycle so an abandoned store never lands.
    assign mem_write  = mem_write_r & ~reset;

    lsu_load_align u_align (
        .word   (mem_read_data),
        .offset (req.offset),
        .funct3 (req.funct3),
        .data   (load_word)
    );

    assign lane_mask = size_mask(req.funct3[1:0]) << {req.offset, 3'b000};
    assign merged    = (mem_read_data & ~lane_mask) |
                       ((req.store_data << {req.offset, 3'b000}) & lane_mask);

    always_comb begin
        req_bad = 1'b0;
        if (is_load == is_store)            req_bad = 1'b1;
        if (is_load && funct3 == 3'd7)      req_bad = 1'b1;
        if (is_store && funct3[2])          req_bad = 1'b1;
        case (funct3[1:0])
            2'd1:    if (addr[0])          req_bad = 1'b1;
            2'd2:    if (addr[1:0] != 2'd0) req_bad = 1'b1;
            2'd3:    if (addr[2:0] != 3'd0) req_bad = 1'b1;
            default: ;
        endcase
        if ({3'b000, addr[63:3]} >= 64'(MEM_DEPTH)) req_bad = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            req            <= '0;
            fault          <= 1'b0;
            load_data      <= '0;
            mem_read       <= 1'b0;
            mem_write_r    <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    req.is_load    <= is_load;
                    req.funct3     <= funct3;
                    req.offset     <= addr[2:0];
                    req.store_data <= store_data;
                    mem_address    <= {3'b000, addr[63:3]};
                    if (req_bad) begin
                        fault     <= 1'b1;
                        load_data <= '0;
                        state     <= RESP;
                    end else begin
                        state <= ACCESS;
                        if (is_load || funct3 != F3_SD) begin
                            mem_read <= 1'b1;
                        end else begin
                            mem_write_r    <= 1'b1;
                            mem_write_data <= store_data;
                        end
                    end
                end
                ACCESS: begin
                    mem_read    <= 1'b0;
                    mem_write_r <= 1'b0;
                    if (req.is_load) begin
                        load_data <= load_word;
                        fault     <= 1'b0;
                        state     <= RESP;
                    end else if (req.funct3 == F3_SD) begin
                        load_data <= '0;
                        fault     <= 1'b0;
                        state     <= RESP;
                    end else begin
                        mem_write_data <= merged;
                        mem_write_r    <= 1'b1;
                        state          <= RMW_WRITE;
                    end
                end
                RMW_WRITE: begin
                    mem_write_r <= 1'b0;
                    load_data   <= '0;
                    fault       <= 1'b0;
                    state       <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
